// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and widths.
package pll_rst_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    localparam logic [STATE_W-1:0] S_WAIT_LOCK = 3'd0;
    localparam logic [STATE_W-1:0] S_STABILIZE = 3'd1;
    localparam logic [STATE_W-1:0] S_RUN       = 3'd2;
    localparam logic [STATE_W-1:0] S_HOLD      = 3'd3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = S_WAIT_LOCK,
        STABILIZE = S_STABILIZE,
        RUN       = S_RUN,
        HOLD      = S_HOLD
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// System reset generator for the PLL output domain: waits for a stable LOCK,
// releases sys_reset_n, re-asserts on filtered lock loss. Optional LOCK_LOSS_COUNT_EN adds a loss counter.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int FILTER_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               locked,
    output logic               sys_reset_n,
    output logic               sys_ready,
    output logic [STATE_W-1:0] state
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
`endif
);

    localparam int MAX_CYCLES = max3(STABLE_CYCLES, HOLD_CYCLES, FILTER_CYCLES);
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic       w_rst_n;
    logic       w_lock_sync;

    state_t     r_state;
    state_t     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] w_lcnt_next;
    logic       r_sys_reset_n;
    logic       w_sys_reset_n_next;
    logic       r_sys_ready;
    logic       w_sys_ready_next;

    // Assertion of reset_n propagates asynchronously; release is retimed to clock_in.
    sync_bit #(
        .STAGES (2)
    ) u_rst_sync (
        .i_clk   (clock_in),
        .i_rst_n (reset_n),
        .i_d     (1'b1),
        .o_q     (w_rst_n)
    );

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clock_in),
        .i_rst_n (w_rst_n),
        .i_d     (locked),
        .o_q     (w_lock_sync)
    );

    always_ff @(posedge clock_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= WAIT_LOCK;
            r_cnt         <= '0;
            r_lcnt        <= '0;
            r_sys_reset_n <= 1'b0;
            r_sys_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_lcnt        <= w_lcnt_next;
            r_sys_reset_n <= w_sys_reset_n_next;
            r_sys_ready   <= w_sys_ready_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_lcnt_next        = r_lcnt;
        w_sys_reset_n_next = 1'b0;

        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_sync) begin
                    w_state_next = STABILIZE;
                    w_cnt_next   = '0;
                end
            end
            STABILIZE: begin
                if (!w_lock_sync) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next       = RUN;
                    w_lcnt_next        = '0;
                    w_sys_reset_n_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RUN: begin
                w_sys_reset_n_next = 1'b1;
                if (w_lock_sync) begin
                    w_lcnt_next = '0;
                end else if (r_lcnt == FILTER_LAST) begin
                    w_state_next       = HOLD;
                    w_cnt_next         = '0;
                    w_sys_reset_n_next = 1'b0;
                end else begin
                    w_lcnt_next = r_lcnt + 1'b1;
                end
            end
            HOLD: begin
                // Lock state is ignored here so every relock goes through a full STABILIZE.
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_LOCK;
                w_cnt_next   = '0;
            end
        endcase

        w_sys_ready_next = w_sys_reset_n_next & r_sys_reset_n;
    end

    assign sys_reset_n = r_sys_reset_n;
    assign sys_ready   = r_sys_ready;
    assign state       = r_state;

`ifdef LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  w_loss_event;

    assign w_loss_event = (r_state == RUN) && (w_state_next == HOLD);

    always_ff @(posedge clock_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (STABLE=16, FILTER=4, HOLD=16).
module tb_pll_reset_sequencer;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       locked;
    logic       sys_reset_n;
    logic       sys_ready;
    logic [2:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock_in = ~clock_in;

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .FILTER_CYCLES (4),
        .HOLD_CYCLES   (16)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .locked      (locked),
        .sys_reset_n (sys_reset_n),
        .sys_ready   (sys_ready),
        .state       (state)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // Raise locked now; the next edge is k. Release must land exactly after edge k+18.
    task automatic expect_release(input string tag);
        locked = 1'b1;
        tick(18);
        check_eq({tag, "_rst_k17"}, sys_reset_n, 0);
        check_eq({tag, "_state_k17"}, state, 1);
        tick(1);
        check_eq({tag, "_rst_k18"}, sys_reset_n, 1);
        check_eq({tag, "_rdy_k18"}, sys_ready, 0);
        check_eq({tag, "_state_k18"}, state, 2);
        tick(1);
        check_eq({tag, "_rdy_k19"}, sys_ready, 1);
    endtask

    task automatic bring_up(input string tag);
        locked  = 1'b0;
        reset_n = 1'b1;
        tick(4);
        expect_release(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        locked  = 1'b1;

        // Reset state with locked high
        tick(3);
        check_eq("rst_sys_reset_n", sys_reset_n, 0);
        check_eq("rst_sys_ready", sys_ready, 0);
        check_eq("rst_state", state, 0);
`ifdef LOCK_LOSS_COUNT_EN
        check_eq("rst_loss_cnt", lock_loss_count, 0);
`endif
        bring_up("release");

        // Lock drop during STABILIZE at cnt=10, then full relock
        reset_n = 1'b0;
        tick(2);
        locked  = 1'b0;
        reset_n = 1'b1;
        tick(4);
        locked = 1'b1;
        tick(13);
        check_eq("stab_cnt10_state", state, 1);
        locked = 1'b0;
        tick(2);
        check_eq("stab_drop_e2_state", state, 1);
        tick(1);
        check_eq("stab_drop_e3_state", state, 0);
        expect_release("relock");

        // Short drop of 3 cycles is filtered out
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_eq($sformatf("drop3_state_%0d", i), state, 2);
            check_eq($sformatf("drop3_rst_%0d", i), sys_reset_n, 1);
            check_eq($sformatf("drop3_rdy_%0d", i), sys_ready, 1);
        end

        // Drop of 4 cycles: HOLD entered at the 6th edge, lasts 16 edges
        locked = 1'b0;
        tick(4);
        locked = 1'b1;
        tick(1);
        check_eq("drop4_e5_state", state, 2);
        check_eq("drop4_e5_rst", sys_reset_n, 1);
        tick(1);
        check_eq("drop4_e6_state", state, 3);
        check_eq("drop4_e6_rst", sys_reset_n, 0);
        check_eq("drop4_e6_rdy", sys_ready, 0);
        tick(15);
        check_eq("hold_last_state", state, 3);
        check_eq("hold_last_rst", sys_reset_n, 0);
        tick(1);
        check_eq("hold_exit_state", state, 0);
        tick(1);
        check_eq("relock_stab_state", state, 1);

        // reset_n mid-STABILIZE
        tick(5);
        check_eq("mid_stab_state", state, 1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_stab_state", state, 0);
        check_eq("arst_stab_rst", sys_reset_n, 0);
        tick(2);

        // reset_n mid-RUN: outputs drop before the next edge
        bring_up("rerun");
        reset_n = 1'b0;
        #1;
        check_eq("arst_run_rst", sys_reset_n, 0);
        check_eq("arst_run_rdy", sys_ready, 0);
        check_eq("arst_run_state", state, 0);
`ifdef LOCK_LOSS_COUNT_EN
        check_eq("arst_run_loss_cnt", lock_loss_count, 0);
`endif
        tick(2);

        // locked low for 10000 cycles after reset
        locked  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1000);
            check_eq($sformatf("nolock_rst_%0d", i), sys_reset_n, 0);
            check_eq($sformatf("nolock_state_%0d", i), state, 0);
        end

`ifdef LOCK_LOSS_COUNT_EN
        // 300 filtered loss/relock cycles: saturate at 255
        locked = 1'b1;
        tick(20);
        check_eq("loss_start_state", state, 2);
        check_eq("loss_start_cnt", lock_loss_count, 0);
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick(24);
            locked = 1'b1;
            tick(20);
            check_eq($sformatf("loss_cnt_%0d", i), lock_loss_count, (i + 1 > 255) ? 255 : i + 1);
        end
        check_eq("loss_final_state", state, 2);
        reset_n = 1'b0;
        #1;
        check_eq("loss_cnt_cleared", lock_loss_count, 0);
        tick(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
